// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg
// Shared types and constants for the three-group round-robin arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [1:0] GRP_A = 2'd0;
   localparam logic [1:0] GRP_B = 2'd1;
   localparam logic [1:0] GRP_C = 2'd2;

   localparam logic [2:0] GNT_NONE = 3'b000;
   localparam logic [2:0] GNT_A    = 3'b001;
   localparam logic [2:0] GNT_B    = 3'b010;
   localparam logic [2:0] GNT_C    = 3'b100;

   // Pointer starts at C so that A has first priority after reset.
   localparam logic [1:0] PTR_RST = GRP_C;

   function automatic logic [1:0] grp_next(input logic [1:0] g);
      return (g == GRP_C) ? GRP_A : g + 2'd1;
   endfunction

   function automatic logic [1:0] oh2grp(input logic [2:0] oh);
      case (oh)
         GNT_B:   return GRP_B;
         GNT_C:   return GRP_C;
         default: return GRP_A;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick
// Combinational rotate-priority picker; search starts after the pointer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick
   import gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg::*;
(
   input  logic [2:0] i_req,
   input  logic [1:0] i_ptr,
   output logic [2:0] o_pick,
   output logic       o_found
);

   logic [1:0] w_idx;

   always_comb begin
      o_pick  = GNT_NONE;
      o_found = 1'b0;
      w_idx   = i_ptr;
      for (int k = 0; k < 3; k++) begin
         w_idx = grp_next(w_idx);
         if (!o_found && i_req[w_idx]) begin
            o_pick[w_idx] = 1'b1;
            o_found       = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_func.sv
// ----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__rrarb3_func
// Three-group round-robin arbiter with grant hold, timeout and ZN request term.
// Optional A-priority input HP via GF180MCU_FD_SC_MCU7T5V0__RRARB3_PRIO_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__rrarb3_func
   import gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic       CLK,
   input  logic       RN,
   input  logic       A1,
   input  logic       A2,
   input  logic       B1,
   input  logic       B2,
   input  logic       C1,
   input  logic       C2,
   input  logic       DONE,
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB3_PRIO_EN
   input  logic       HP,
`endif
   output logic [2:0] GNT,
   output logic       VLD,
   output logic       TMO,
   output logic       ZN
);

   localparam int CNT_W = ($clog2(HOLD_MAX + 1) < 1) ? 1 : $clog2(HOLD_MAX + 1);
   localparam logic             c_to_en    = (HOLD_MAX != 0);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_gnt;
   logic [2:0]       w_gnt_nxt;
   logic [1:0]       r_ptr;
   logic [1:0]       w_ptr_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_vld;
   logic             r_tmo;
   logic             w_tmo_nxt;

   logic [2:0] w_req;
   logic [2:0] w_mask;
   logic [2:0] w_pick;
   logic       w_found;
   logic       w_hold_req;
   logic       w_timeout;
   logic       w_release;
   logic       w_arb;
   logic       w_hp_a;

   assign w_req      = {C1 | C2, B1 | B2, A1 | A2};
   assign w_hold_req = |(r_gnt & w_req);
   assign w_timeout  = c_to_en && (r_cnt == c_cnt_last);
   assign w_release  = DONE | ~w_hold_req | w_timeout;
   assign w_arb      = (r_state == IDLE) || w_release;
   // The releasing holder is excluded so another requester gets its turn.
   assign w_mask     = (r_state == GRANT) ? (w_req & ~r_gnt) : w_req;

`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB3_PRIO_EN
   assign w_hp_a = HP & w_req[GRP_A];
`else
   assign w_hp_a = 1'b0;
`endif

   gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick u_pick (
      .i_req   (w_mask),
      .i_ptr   (r_ptr),
      .o_pick  (w_pick),
      .o_found (w_found)
   );

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state <= IDLE;
         r_gnt   <= GNT_NONE;
         r_ptr   <= PTR_RST;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
         r_tmo   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_vld   <= |w_gnt_nxt;
         r_tmo   <= w_tmo_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (|w_req) w_state_nxt = GRANT;
         GRANT:   if (w_release && !w_found && !w_hold_req && !w_hp_a) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_gnt_nxt = r_gnt;
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_cnt;
      w_tmo_nxt = 1'b0;
      if (w_arb) begin
         w_cnt_nxt = '0;
         // HP grants leave the pointer alone so rotation resumes unchanged.
         if (w_hp_a) begin
            w_gnt_nxt = GNT_A;
         end else if (w_found) begin
            w_gnt_nxt = w_pick;
            w_ptr_nxt = oh2grp(w_pick);
         end else if ((r_state == GRANT) && w_hold_req) begin
            w_gnt_nxt = r_gnt;
         end else begin
            w_gnt_nxt = GNT_NONE;
         end
         if (r_state == GRANT) w_tmo_nxt = w_timeout & ~DONE & w_hold_req;
      end else if (c_to_en) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   assign GNT = r_gnt;
   assign VLD = r_vld;
   assign TMO = r_tmo;
   assign ZN  = ~(&w_req);

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3_func.sv
// ----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3_func
// Directed self-checking bench for the three-group arbiter (HOLD_MAX=4).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3_func;

   logic       CLK = 1'b0;
   logic       RN, A1, A2, B1, B2, C1, C2, DONE;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB3_PRIO_EN
   logic       HP;
`endif
   logic [2:0] GNT;
   logic       VLD, TMO, ZN;

   int n_pass  = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   gf180mcu_fd_sc_mcu7t5v0__rrarb3_func #(.HOLD_MAX(4)) dut (
      .CLK  (CLK),
      .RN   (RN),
      .A1   (A1),
      .A2   (A2),
      .B1   (B1),
      .B2   (B2),
      .C1   (C1),
      .C2   (C2),
      .DONE (DONE),
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB3_PRIO_EN
      .HP   (HP),
`endif
      .GNT  (GNT),
      .VLD  (VLD),
      .TMO  (TMO),
      .ZN   (ZN)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] eg, input logic ev, input logic et);
      n_total++;
      assert ({GNT, VLD, TMO} === {eg, ev, et}) n_pass++;
      else $error("FAIL %s: observed GNT=%b VLD=%b TMO=%b expected GNT=%b VLD=%b TMO=%b",
                  tag, GNT, VLD, TMO, eg, ev, et);
   endtask

   task automatic chk_zn(input string tag, input logic ez);
      n_total++;
      assert (ZN === ez) n_pass++;
      else $error("FAIL %s: observed ZN=%b expected ZN=%b", tag, ZN, ez);
   endtask

   initial begin
      RN = 1'b0; DONE = 1'b0;
      A1 = 1'b0; A2 = 1'b0; B1 = 1'b0; B2 = 1'b0; C1 = 1'b0; C2 = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB3_PRIO_EN
      HP = 1'b0;
`endif
      #3;
      chk("reset", 3'b000, 1'b0, 1'b0);
      chk_zn("reset_zn", 1'b1);
      tick(); tick();
      RN = 1'b1;
      tick();
      chk("idle_after_reset", 3'b000, 1'b0, 1'b0);

      // Single request A, then drop
      A1 = 1'b1;
      tick(); chk("a_grant", 3'b001, 1'b1, 1'b0);
      A1 = 1'b0;
      tick(); chk("a_drop", 3'b000, 1'b0, 1'b0);

      // All three request; pointer at A so rotation runs B, C, A, B
      A2 = 1'b1; B2 = 1'b1; C1 = 1'b1;
      #1; chk_zn("all_req_zn", 1'b0);
      tick(); chk("rot_b", 3'b010, 1'b1, 1'b0);
      DONE = 1'b1;
      tick(); chk("rot_c", 3'b100, 1'b1, 1'b0); chk_zn("rot_zn_c", 1'b0);
      tick(); chk("rot_a", 3'b001, 1'b1, 1'b0);
      tick(); chk("rot_b2", 3'b010, 1'b1, 1'b0); chk_zn("rot_zn_b", 1'b0);
      DONE = 1'b0; A2 = 1'b0; B2 = 1'b0; C1 = 1'b0;
      #1; chk_zn("no_req_zn", 1'b1);
      tick(); chk("rot_idle", 3'b000, 1'b0, 1'b0);

      // Timeout: pointer at B so C wins first, held 4 cycles, then B
      B1 = 1'b1; C2 = 1'b1;
      #1; chk_zn("two_req_zn", 1'b1);
      tick(); chk("to_c0", 3'b100, 1'b1, 1'b0);
      tick(); chk("to_c1", 3'b100, 1'b1, 1'b0);
      tick(); chk("to_c2", 3'b100, 1'b1, 1'b0);
      tick(); chk("to_c3", 3'b100, 1'b1, 1'b0);
      tick(); chk("to_switch_b", 3'b010, 1'b1, 1'b1);
      tick(); chk("to_pulse_end", 3'b010, 1'b1, 1'b0);

      // Asynchronous reset mid-grant, then A wins first
      #1; RN = 1'b0;
      #1; chk("async_reset", 3'b000, 1'b0, 1'b0);
      A1 = 1'b1;
      #1; RN = 1'b1;
      tick(); chk("post_reset_a", 3'b001, 1'b1, 1'b0);

      // Single requester C re-granted on DONE, then timeout re-grant
      A1 = 1'b0; B1 = 1'b0;
      tick(); chk("c_after_a_drop", 3'b100, 1'b1, 1'b0);
      DONE = 1'b1;
      tick(); chk("c_regrant1", 3'b100, 1'b1, 1'b0);
      tick(); chk("c_regrant2", 3'b100, 1'b1, 1'b0);
      DONE = 1'b0;
      tick(); tick(); tick();
      chk("c_hold3", 3'b100, 1'b1, 1'b0);
      tick(); chk("c_timeout_regrant", 3'b100, 1'b1, 1'b1);

      // DONE while idle has no effect
      C2 = 1'b0;
      tick(); chk("c_drop_idle", 3'b000, 1'b0, 1'b0);
      DONE = 1'b1;
      tick(); chk("done_idle", 3'b000, 1'b0, 1'b0);
      DONE = 1'b0;

`ifdef GF180MCU_FD_SC_MCU7T5V0__RRARB3_PRIO_EN
      // Pointer is C; HP keeps A winning and leaves the pointer untouched
      HP = 1'b1; A1 = 1'b1; B1 = 1'b1;
      tick(); chk("hp_a0", 3'b001, 1'b1, 1'b0);
      DONE = 1'b1;
      tick(); chk("hp_a1", 3'b001, 1'b1, 1'b0);
      tick(); chk("hp_a2", 3'b001, 1'b1, 1'b0);
      HP = 1'b0;
      tick(); chk("rr_b", 3'b010, 1'b1, 1'b0);
      tick(); chk("rr_a", 3'b001, 1'b1, 1'b0);
      tick(); chk("rr_b2", 3'b010, 1'b1, 1'b0);
      DONE = 1'b0; A1 = 1'b0; B1 = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
